// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the CDC FIFO: memory write enable/address, binary and Gray
// write pointers, and full, almost-full and sticky overflow flags in the write clock domain.
module fifo_wr_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 7,
    parameter int unsigned AFULL_THRESH = 120
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_winc,
    input  logic [ADDR_WIDTH:0]   i_wq2_rptr,
    output logic                  o_wclken,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [ADDR_WIDTH:0]   o_wptr,
    output logic                  o_wfull,
    output logic                  o_walmost_full,
    output logic                  o_wovf
);

    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_LEVEL = PW'(AFULL_THRESH);

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wptr;
    logic          r_wfull;
    logic          r_walmost_full;
    logic          r_wovf;

    logic          w_wclken;
    logic [PW-1:0] w_wbin_nxt;
    logic [PW-1:0] w_wgray_nxt;
    logic [PW-1:0] w_rptr_full;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_level;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = int'(PW) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Reset also blocks the memory write so nothing is committed while the pointer is held at 0.
    assign w_wclken    = i_winc & ~r_wfull & ~i_rst;
    assign w_wbin_nxt  = r_wbin + PW'(w_wclken);
    assign w_wgray_nxt = (w_wbin_nxt >> 1) ^ w_wbin_nxt;

    // Full when the next write pointer is exactly one lap ahead of the synchronised read pointer.
    assign w_rptr_full = {~i_wq2_rptr[AW:AW-1], i_wq2_rptr[AW-2:0]};
    assign w_rbin      = gray2bin(i_wq2_rptr);
    assign w_level     = w_wbin_nxt - w_rbin;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wovf         <= 1'b0;
        end else begin
            r_wbin         <= w_wbin_nxt;
            r_wptr         <= w_wgray_nxt;
            r_wfull        <= (w_wgray_nxt == w_rptr_full);
            r_walmost_full <= (w_level >= AFULL_LEVEL);
            if (i_winc && r_wfull) begin
                r_wovf <= 1'b1;
            end
        end
    end

    assign o_wclken       = w_wclken;
    assign o_waddr        = r_wbin[AW-1:0];
    assign o_wptr         = r_wptr;
    assign o_wfull        = r_wfull;
    assign o_walmost_full = r_walmost_full;
    assign o_wovf         = r_wovf;

endmodule
